// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: aligned multi-lane fetch groups, prioritised redirects, BTB truncation,
// and a request FIFO. Define FETCH_PC_GEN_BYPASS_EN to drive a new group straight out when empty.
module fetch_pc_gen #(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter int unsigned NUM_REDIRECT = 3,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    localparam int unsigned LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic [NUM_REDIRECT-1:0]   redir_valid,
    input  logic [32*NUM_REDIRECT-1:0] redir_pc,
    output logic [31:0]               btb_pc,
    input  logic                      btb_valid,
    input  logic [LW-1:0]             btb_lane,
    input  logic [31:0]               btb_npc,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [31:0]               req_pc,
    output logic [FETCH_WIDTH-1:0]    req_mask,
    output logic [31:0]               req_npc,
    output logic                      req_taken,
    output logic [CW-1:0]             count_o
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [31:0]            pc;
        logic [FETCH_WIDTH-1:0] mask;
        logic [31:0]            npc;
        logic                   taken;
    } entry_t;

    logic [31:0]   pc_r, pc_d;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    entry_t        mem_q [BUF_DEPTH];

    logic [LW-1:0] start;
    logic          hit;
    logic [31:0]   base, seq_npc;
    entry_t        grp, head;
    logic          redir_any;
    logic [31:0]   redir_tgt;
    logic          empty, full, enq, deq, bypass, push, pop;

    always_comb begin
        base    = pc_r & ~32'(4 * FETCH_WIDTH - 1);
        seq_npc = base + 32'(4 * FETCH_WIDTH);
        start   = LW'((pc_r >> 2) & 32'(FETCH_WIDTH - 1));
        // A predicted branch in a lane before the entry point belongs to code we skip.
        hit     = btb_valid && (btb_lane >= start);
        grp.pc    = pc_r;
        grp.npc   = hit ? btb_npc : seq_npc;
        grp.taken = hit;
        grp.mask  = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            grp.mask[k] = (k >= int'(start)) && (!hit || (k <= int'(btb_lane)));
        end
    end

    always_comb begin
        redir_any = |redir_valid;
        redir_tgt = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redir_valid[i]) redir_tgt = redir_pc[32*i +: 32];
        end
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(BUF_DEPTH));
        enq   = !redir_any && !stall_i && !full;
`ifdef FETCH_PC_GEN_BYPASS_EN
        bypass = empty && enq;
`else
        bypass = 1'b0;
`endif
        req_valid = !empty || bypass;
        head      = bypass ? grp : mem_q[rd_ptr];
        if (!req_valid) head = '0;
        deq  = req_valid && req_ready && !redir_any;
        // A bypassed group that is accepted immediately never touches the FIFO.
        push = enq && !(bypass && req_ready);
        pop  = deq && !empty;
        if (redir_any)  pc_d = redir_tgt;
        else if (enq)   pc_d = grp.npc;
        else            pc_d = pc_r;
    end

    assign btb_pc    = pc_d;
    assign req_pc    = head.pc;
    assign req_mask  = head.mask;
    assign req_npc   = head.npc;
    assign req_taken = head.taken;
    assign count_o   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            pc_r <= pc_d;
            if (redir_any) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= grp;
    end

endmodule
